// File: rtl/wb_result_sel.sv
// Write-back result select for the RV64 core: one registered RF write port.
// Optional WB_COMMIT_TRACE_EN adds commit_valid/commit_pc for difftest.
module wb_result_sel #(
  parameter int TIMEOUT = 255,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [63:0]     in_alu_res,
  input  logic [63:0]     in_imm,
  input  logic [1:0]      in_wb_sel,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [2:0]      in_load_fmt,
  input  logic            mem_rvalid,
  input  logic [63:0]     mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [63:0]     rf_wdata,
  output logic            load_err
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic            commit_valid,
  output logic [PC_W-1:0] commit_pc
`endif
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  off_q;
  logic [2:0]  fmt_q;
  logic [4:0]  rd_q;
  logic        we_q;
`ifdef WB_COMMIT_TRACE_EN
  logic [PC_W-1:0] pc_q;
`endif

  logic        accept;
  logic        wr_ok;
  logic [63:0] sel_data;
  logic [63:0] ld_data;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = in_rd_we && (in_rd != 5'd0);

  function automatic logic [63:0] fmt_load(
    input logic [63:0] d,
    input logic [2:0]  off,
    input logic [2:0]  f
  );
    logic [63:0] s;
    // Bytes past the doubleword read as zero; no split access.
    s = d >> {off, 3'b000};
    case (f)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  assign ld_data = fmt_load(mem_rdata, off_q, fmt_q);

  always_comb begin
    sel_data = in_alu_res;
    unique case (1'b1)
      (in_wb_sel == 2'b10): sel_data = 64'(in_pc) + 64'd4;
      (in_wb_sel == 2'b11): sel_data = in_imm;
      default:              sel_data = in_alu_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      off_q    <= '0;
      fmt_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      load_err <= 1'b0;
`ifdef WB_COMMIT_TRACE_EN
      pc_q         <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
`endif
    end else begin
      rf_we    <= 1'b0;
      load_err <= 1'b0;
`ifdef WB_COMMIT_TRACE_EN
      commit_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            off_q <= in_alu_res[2:0];
            fmt_q <= in_load_fmt;
            rd_q  <= in_rd;
            we_q  <= wr_ok;
`ifdef WB_COMMIT_TRACE_EN
            pc_q  <= in_pc;
`endif
            if (in_wb_sel == 2'b01) begin
              state <= WAIT;
              cnt   <= '0;
            end else begin
              rf_we <= wr_ok;
              if (wr_ok) begin
                rf_waddr <= in_rd;
                rf_wdata <= sel_data;
              end
`ifdef WB_COMMIT_TRACE_EN
              commit_valid <= 1'b1;
              commit_pc    <= in_pc;
`endif
            end
          end
        end
        WAIT: begin
          // A response on the timeout edge still completes the load.
          if (mem_rvalid) begin
            state <= IDLE;
            rf_we <= we_q;
            if (we_q) begin
              rf_waddr <= rd_q;
              rf_wdata <= ld_data;
            end
`ifdef WB_COMMIT_TRACE_EN
            commit_valid <= 1'b1;
            commit_pc    <= pc_q;
`endif
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            load_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
